// File: rtl/conv1d_relu_stream_if.sv
// Valid/ready stream bundle carrying one data word plus an end-of-frame marker.
interface conv1d_relu_stream_if #(
  parameter int unsigned DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/conv1d_relu_stream.sv
// Streamed valid 1-D convolution with fused bias and ReLU; one time-shared
// multiplier performs one MAC per cycle under a four-state sequencer.
module conv1d_relu_stream #(
  parameter  int unsigned KERNEL = 3,
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned FRAC   = 8,
  localparam int unsigned AW     = $clog2(KERNEL)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  conv1d_relu_stream_if.slave   in_if,
  conv1d_relu_stream_if.master  out_if,
  input  logic                  coef_we_i,
  input  logic [AW-1:0]         coef_addr_i,
  input  logic [DATA_W-1:0]     coef_wdata_i,
  input  logic                  bias_we_i,
  input  logic [DATA_W-1:0]     bias_wdata_i,
  output logic                  busy_o,
  output logic                  err_short_o
);

  localparam int unsigned FW    = $clog2(KERNEL + 1);
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned ACC_W = 2 * DATA_W + AW + 1;

  localparam logic [1:0] S_ACCEPT = 2'd0;
  localparam logic [1:0] S_MAC    = 2'd1;
  localparam logic [1:0] S_ROUND  = 2'd2;
  localparam logic [1:0] S_EMIT   = 2'd3;

  localparam logic signed [ACC_W-1:0] MAX_POS = ACC_W'(2 ** (DATA_W - 1) - 1);

  logic [1:0]               state_q, state_d;
  logic [FW-1:0]            fill_q, fill_d;
  logic [AW-1:0]            tap_q, tap_d;
  logic signed [DATA_W-1:0] win_q  [KERNEL];
  logic signed [DATA_W-1:0] win_d  [KERNEL];
  logic signed [DATA_W-1:0] coef_q [KERNEL];
  logic signed [DATA_W-1:0] coef_d [KERNEL];
  logic signed [DATA_W-1:0] bias_q, bias_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     pend_last_q, pend_last_d;
  logic                     in_ready_q, in_ready_d;
  logic                     busy_q, busy_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     err_short_q, err_short_d;

  logic                     in_hs_c;
  logic [FW-1:0]            fill_inc_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [ACC_W-1:0]  bias_sh_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  res_c;
  logic [DATA_W-1:0]        sat_c;

  assign in_hs_c    = in_if.valid & in_ready_q;
  assign fill_inc_c = (fill_q == FW'(KERNEL)) ? fill_q : fill_q + FW'(1);
  assign prod_c     = PW'(win_q[tap_q]) * PW'(coef_q[tap_q]);
  assign bias_sh_c  = ACC_W'(bias_q) <<< FRAC;
  assign sum_c      = acc_q + bias_sh_c;
  assign res_c      = sum_c >>> FRAC;

  // ReLU below zero, saturate above the largest positive output word.
  always_comb begin
    sat_c = res_c[DATA_W-1:0];
    if (res_c[ACC_W-1]) begin
      sat_c = '0;
    end else if (res_c > MAX_POS) begin
      sat_c = MAX_POS[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    tap_d       = tap_q;
    win_d       = win_q;
    coef_d      = coef_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    pend_last_d = pend_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_short_d = 1'b0;

    // Configuration is only writable while idle so a running MAC sees stable taps.
    if (!busy_q) begin
      if (coef_we_i && (32'(coef_addr_i) < KERNEL)) begin
        coef_d[coef_addr_i] = $signed(coef_wdata_i);
      end
      if (bias_we_i) begin
        bias_d = $signed(bias_wdata_i);
      end
    end

    case (state_q)
      S_ACCEPT: begin
        if (in_hs_c) begin
          for (int i = 0; i < int'(KERNEL) - 1; i++) begin
            win_d[AW'(i)] = win_q[AW'(i + 1)];
          end
          win_d[AW'(KERNEL - 1)] = $signed(in_if.data);
          if (fill_inc_c == FW'(KERNEL)) begin
            fill_d      = fill_inc_c;
            pend_last_d = in_if.last;
            acc_d       = '0;
            tap_d       = '0;
            state_d     = S_MAC;
          end else if (in_if.last) begin
            fill_d      = '0;
            err_short_d = 1'b1;
          end else begin
            fill_d      = fill_inc_c;
          end
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_c);
        tap_d = tap_q + AW'(1);
        if (tap_q == AW'(KERNEL - 1)) begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        out_data_d  = sat_c;
        out_last_d  = pend_last_q;
        out_valid_d = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_if.ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            fill_d = '0;
            win_d  = '{default: '0};
          end
          state_d = S_ACCEPT;
        end
      end
      default: state_d = S_ACCEPT;
    endcase

    in_ready_d = (state_d == S_ACCEPT);
    busy_d     = (state_d != S_ACCEPT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_ACCEPT;
      fill_q      <= '0;
      tap_q       <= '0;
      win_q       <= '{default: '0};
      coef_q      <= '{default: '0};
      bias_q      <= '0;
      acc_q       <= '0;
      pend_last_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      tap_q       <= tap_d;
      win_q       <= win_d;
      coef_q      <= coef_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      pend_last_q <= pend_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_short_q <= err_short_d;
    end
  end

  assign in_if.ready  = in_ready_q;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.last  = out_last_q;
  assign busy_o       = busy_q;
  assign err_short_o  = err_short_q;

endmodule

// File: tb/tb_conv1d_relu_stream.sv
// Directed bench for conv1d_relu_stream: hand-computed outputs, latency,
// backpressure, short frames, dropped writes and mid-operation reset.
module tb_conv1d_relu_stream;

  localparam int unsigned KERNEL = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned AW     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [DATA_W-1:0] coef_wdata = '0;
  logic              bias_we = 1'b0;
  logic [DATA_W-1:0] bias_wdata = '0;
  logic              busy;
  logic              err_short;

  always #5 clk = ~clk;

  conv1d_relu_stream_if #(.DATA_W(DATA_W)) in_if ();
  conv1d_relu_stream_if #(.DATA_W(DATA_W)) out_if ();

  conv1d_relu_stream #(.KERNEL(KERNEL), .DATA_W(DATA_W), .FRAC(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_if        (in_if),
    .out_if       (out_if),
    .coef_we_i    (coef_we),
    .coef_addr_i  (coef_addr),
    .coef_wdata_i (coef_wdata),
    .bias_we_i    (bias_we),
    .bias_wdata_i (bias_wdata),
    .busy_o       (busy),
    .err_short_o  (err_short)
  );

  int          n_checks = 0;
  int          n_fails  = 0;
  int          err_cnt  = 0;
  logic [16:0] outq[$];

  // Record each output transfer and each short-frame pulse.
  always @(negedge clk) begin
    if (out_if.valid && out_if.ready) outq.push_back({out_if.last, out_if.data});
    if (err_short) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    int g;
    g = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.last  = l;
    while (!in_if.ready && g < 200) begin
      tick();
      g++;
    end
    if (!in_if.ready) check("send_ready_timeout", 32'(in_if.ready), 32'd1);
    tick();
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [DATA_W-1:0] d, input logic l);
    int g;
    logic [16:0] v;
    g = 0;
    while (outq.size() == 0 && g < 200) begin
      tick();
      g++;
    end
    check({tag, "_present"}, 32'(outq.size() > 0), 32'd1);
    if (outq.size() > 0) begin
      v = outq.pop_front();
      check({tag, "_data"}, 32'(v[15:0]), 32'(d));
      check({tag, "_last"}, 32'(v[16]), 32'(l));
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [DATA_W-1:0] v);
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    tick();
    coef_we    = 1'b0;
  endtask

  task automatic load(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] c1,
                      input logic [DATA_W-1:0] c2, input logic [DATA_W-1:0] b);
    write_coef(2'd0, c0);
    write_coef(2'd1, c1);
    write_coef(2'd2, c2);
    bias_we    = 1'b1;
    bias_wdata = b;
    tick();
    bias_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic stable;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;

    // Reset state, then release mid-cycle.
    tick(2);
    check("rst_out_valid", 32'(out_if.valid), 32'd0);
    check("rst_out_data", 32'(out_if.data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_if.ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Basic convolution and latency.
    load(16'h0100, 16'h0100, 16'h0100, 16'h0000);
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
    check("s2_in_ready_low", 32'(in_if.ready), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_if.valid && lat < 20) begin
      tick();
      lat++;
    end
    check("s2_latency", 32'(lat), 32'd4);
    send(16'h0400, 1'b0);
    send(16'h0500, 1'b1);
    expect_out("s2_o0", 16'h0600, 1'b0);
    expect_out("s2_o1", 16'h0900, 1'b0);
    expect_out("s2_o2", 16'h0C00, 1'b1);

    // ReLU clamp and positive saturation.
    load(16'hFF00, 16'h0000, 16'h0000, 16'h0080);
    send(16'h0200, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0200, 1'b1);
    expect_out("s3_relu", 16'h0000, 1'b1);
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    expect_out("s3_sat", 16'h7FFF, 1'b1);

    // Backpressure holds the output stable.
    load(16'h0100, 16'h0100, 16'h0100, 16'h0000);
    out_if.ready = 1'b0;
    send(16'h0100, 1'b0);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
    lat = 0;
    while (!out_if.valid && lat < 20) begin
      tick();
      lat++;
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_if.data !== 16'h0600 || out_if.last !== 1'b0 || in_if.ready !== 1'b0 ||
          busy !== 1'b1 || out_if.valid !== 1'b1) stable = 1'b0;
    end
    check("s4_stable", 32'(stable), 32'd1);
    check("s4_data", 32'(out_if.data), 32'h0600);
    check("s4_in_ready", 32'(in_if.ready), 32'd0);
    out_if.ready = 1'b1;
    send(16'h0400, 1'b0);
    send(16'h0500, 1'b1);
    expect_out("s4_o0", 16'h0600, 1'b0);
    expect_out("s4_o1", 16'h0900, 1'b0);
    expect_out("s4_o2", 16'h0C00, 1'b1);

    // Short frame raises one err_short and produces nothing.
    err_cnt = 0;
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    tick(8);
    check("s5_err_cnt", 32'(err_cnt), 32'd1);
    check("s5_no_out", 32'(outq.size()), 32'd0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    expect_out("s5_o", 16'h0300, 1'b1);
    check("s5_err_once", 32'(err_cnt), 32'd1);

    // Coefficient write while busy is dropped.
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    check("s6_busy", 32'(busy), 32'd1);
    write_coef(2'd0, 16'h0500);
    expect_out("s6_drop", 16'h0300, 1'b1);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    expect_out("s6_drop_persist", 16'h0300, 1'b1);

    // Asynchronous reset during MAC aborts the operation and clears coefficients.
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_out_valid", 32'(out_if.valid), 32'd0);
    check("s6_rst_out_data", 32'(out_if.data), 32'd0);
    check("s6_rst_out_last", 32'(out_if.last), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_err_short", 32'(err_short), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("s6_post_in_ready", 32'(in_if.ready), 32'd1);
    check("s6_post_busy", 32'(busy), 32'd0);
    tick(10);
    check("s6_aborted", 32'(outq.size()), 32'd0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b1);
    expect_out("s6_zero_coef", 16'h0000, 1'b1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/conv1d_relu_stream.md
Name: conv1d_relu_stream

Overview:
Streamed 1-D convolution with fused bias and ReLU. It sits directly upstream of the max-pooling stage and feeds it one 16-bit non-negative feature value per transfer. It consumes a framed stream of signed fixed-point samples and slides a KERNEL-tap window across each frame with no padding ("valid" convolution). A single multiplier is time-shared: one MAC per cycle, sequenced by a small FSM, with valid/ready handshakes on both sides.

Parameters:
KERNEL, 3, number of taps (2..8).
DATA_W, 16, width of the sample, coefficient, bias and output words.
FRAC, 8, number of fractional bits; all words are signed Q(DATA_W-FRAC).FRAC.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
in_data  in  DATA_W  signed sample.
in_last  in  1  marks the final sample of a frame.
out_valid  out  1  output value valid.
out_ready  in  1  downstream accepts the output.
out_data  out  DATA_W  ReLU output, always in 0..2^(DATA_W-1)-1.
out_last  out  1  last output of the frame.
coef_we  in  1  coefficient write strobe.
coef_addr  in  clog2(KERNEL)  tap index (0 = oldest sample).
coef_wdata  in  DATA_W  signed coefficient.
bias_we  in  1  bias write strobe.
bias_wdata  in  DATA_W  signed bias.
busy  out  1  high in any state other than ACCEPT.
err_short  out  1  one-cycle pulse when a frame ends with fewer than KERNEL samples.

Behaviour:
- Reset (asynchronous, active-high): state=ACCEPT; fill count=0; window, coefficients, bias and accumulator are all 0; out_valid=0, out_data=0, out_last=0, err_short=0, busy=0. in_ready=1 as soon as reset deasserts. Coefficients must be reloaded after every reset. A reset in any state aborts the operation in progress and discards it.
- FSM states: ACCEPT, MAC, ROUND, EMIT.
- ACCEPT: in_ready=1. A handshake (in_valid & in_ready) shifts in_data into the window (the newest sample lands at tap KERNEL-1) and increments the fill count, which saturates at KERNEL.
  - If the fill count, including this sample, is at least KERNEL: latch in_last as pending_last and go to MAC.
  - Else, if in_last=1: clear the fill count, pulse err_short in the next cycle, and stay in ACCEPT.
  - Else: stay in ACCEPT.
- MAC: runs for exactly KERNEL cycles, tap index k=0..KERNEL-1. Each cycle does acc += window[k]*coef[k].
  - Each product is full-width signed (2*DATA_W).
  - The accumulator is 2*DATA_W+clog2(KERNEL)+1 bits and is cleared on entry to MAC.
- ROUND: one cycle.
  - sum = acc + (bias sign-extended, shifted left by FRAC).
  - res = sum arithmetically shifted right by FRAC (truncation toward minus infinity).
  - If res<0, res becomes 0 (ReLU). If res>2^(DATA_W-1)-1, res becomes 2^(DATA_W-1)-1.
  - res is registered into out_data; out_last = pending_last.
- EMIT: out_valid=1, with out_data and out_last held stable until out_ready=1.
  - On transfer, out_valid drops in the next cycle.
  - If out_last was set: clear the fill count and window.
  - Return to ACCEPT.
- Latency: for a handshake in cycle N, out_valid is first high in cycle N+KERNEL+2. in_ready is low from cycle N+1 until the output transfers.
- Frame output count: IN_LEN-KERNEL+1 outputs per frame of IN_LEN samples, provided IN_LEN ≥ KERNEL. Frames shorter than KERNEL produce no output and raise err_short.
- Coefficient and bias writes:
  - A write takes effect at the next edge only when busy=0; a write while busy=1 is dropped.
  - coef_addr ≥ KERNEL is ignored.
  - Simultaneous coef_we and bias_we both succeed.
  - A write and an input handshake in the same ACCEPT cycle: the write completes before the MAC that follows.
- out_data is always non-negative, so the downstream unsigned max comparison remains valid.

Test Plan:
1. Reset behaviour: assert reset mid-cycle (asynchronously) -> all outputs 0 immediately. After release, in_ready=1 and busy=0.
2. Basic convolution and latency, KERNEL=3: coefs 0x0100 x3, bias 0; frame 0x0100, 0x0200, 0x0300, 0x0400, 0x0500 with in_last on the fifth sample; out_ready=1 -> outputs 0x0600, 0x0900, 0x0C00, out_last only on 0x0C00. The first out_valid appears 5 cycles after the third handshake.
3. ReLU and saturation:
   - coefs {0xFF00, 0, 0}, bias 0x0080, inputs 0x0200 x3 -> output 0x0000 (-1.5 clamped).
   - coefs 0x7FFF x3, inputs 0x0100 x3 -> output 0x7FFF.
4. Backpressure: hold out_ready=0 for 10 cycles during EMIT -> out_data/out_last stable, in_ready=0, busy=1. After release, the full 3-output sequence from scenario 2 is intact.
5. Short frame: 2 samples with in_last on the second -> no out_valid and one err_short pulse. The next 3-sample frame 0x0100 x3 (coefs 0x0100) -> single output 0x0300 with out_last.
6. Writes and mid-operation reset:
   - coef_we to addr 0 with 0x0500 while busy -> ignored; the output matches the old coefficients.
   - Reset asserted during MAC -> out_valid never rises for that sample, and coefficients read back as 0 (the next output is 0).
